// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: FSM encodings, PC-select codes
// and the end-of-execution decode constants.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_EXEC     = 3'd2,
      ST_MEM_WAIT = 3'd3,
      ST_HALT     = 3'd4
   } seq_state_e;

   localparam logic [1:0] PS_HOLD = 2'b00;
   localparam logic [1:0] PS_INC  = 2'b01;
   localparam logic [1:0] PS_BR   = 2'b10;
   localparam logic [1:0] PS_RET  = 2'b11;

   localparam logic [3:0] HALT_OPCODE = 4'hF;
   localparam logic [3:0] HALT_EOE    = 4'hF;

endpackage

// File: rtl/pc_next_unit.sv
// Combinational next-PC / next-return-address computation. All arithmetic
// wraps modulo 2^PC_W; the offset is sign-extended (or truncated) to PC_W.
module pc_next_unit
   import pc_seq_pkg::*;
#(
   parameter int PC_W  = 8,
   parameter int OFF_W = 8
) (
   input  logic [PC_W-1:0]  pc,
   input  logic [PC_W-1:0]  ret_pc,
   input  logic [1:0]       ps,
   input  logic [OFF_W-1:0] offset,
   input  logic             mp,
   output logic [PC_W-1:0]  next_pc,
   output logic [PC_W-1:0]  next_ret
);

   logic [PC_W-1:0] off_ext;
   logic [PC_W-1:0] pc_inc;

   generate
      if (PC_W > OFF_W) begin : g_sext
         assign off_ext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
      end else if (PC_W == OFF_W) begin : g_same
         assign off_ext = offset;
      end else begin : g_trunc
         assign off_ext = offset[PC_W-1:0];
      end
   endgenerate

   assign pc_inc = pc + PC_W'(1);

   always_comb begin
      next_pc = pc;
      case (ps)
         PS_HOLD: next_pc = pc;
         PS_INC:  next_pc = pc_inc;
         PS_BR:   next_pc = pc + off_ext;
         PS_RET:  next_pc = ret_pc;
         default: next_pc = pc;
      endcase
   end

   // Link and return together swap pc and ret_pc because both use old values.
   assign next_ret = mp ? pc_inc : ret_pc;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer and program counter for the single-issue datapath.
// state        | meaning
// ST_IDLE      | waiting for run
// ST_FETCH     | instruction request outstanding, ir_load on mem_ready
// ST_EXEC      | one-cycle execute, samples control inputs
// ST_MEM_WAIT  | load/store handshake, PC update deferred to completion
// ST_HALT      | stopped until reset
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter int              OFF_W    = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [1:0]       ps,
   input  logic             mp,
   input  logic             md,
   input  logic             mw,
   input  logic             halt,
   input  logic [OFF_W-1:0] offset,
   input  logic             mem_ready,
   output logic             state,
   output logic [PC_W-1:0]  pc,
   output logic [PC_W-1:0]  ret_pc,
   output logic             mem_req,
   output logic             mem_we,
   output logic             ir_load,
   output logic             halted
);

   seq_state_e cur_st;
   seq_state_e nxt_st;

   logic [PC_W-1:0]  pc_q;
   logic [PC_W-1:0]  ret_q;
   logic             state_q;
   logic             halted_q;

   logic [1:0]       lat_ps;
   logic             lat_mp;
   logic             lat_mw;
   logic [OFF_W-1:0] lat_off;

   logic             upd_en;
   logic             use_lat;
   logic [1:0]       sel_ps;
   logic             sel_mp;
   logic [OFF_W-1:0] sel_off;
   logic [PC_W-1:0]  next_pc;
   logic [PC_W-1:0]  next_ret;

   // A memory instruction completes with the control word captured at EXEC exit.
   assign use_lat = (cur_st == ST_MEM_WAIT);
   assign sel_ps  = use_lat ? lat_ps  : ps;
   assign sel_mp  = use_lat ? lat_mp  : mp;
   assign sel_off = use_lat ? lat_off : offset;

   pc_next_unit #(
      .PC_W  (PC_W),
      .OFF_W (OFF_W)
   ) u_pc_next (
      .pc       (pc_q),
      .ret_pc   (ret_q),
      .ps       (sel_ps),
      .offset   (sel_off),
      .mp       (sel_mp),
      .next_pc  (next_pc),
      .next_ret (next_ret)
   );

   always_comb begin
      nxt_st = cur_st;
      upd_en = 1'b0;
      case (cur_st)
         ST_IDLE: begin
            if (run) nxt_st = ST_FETCH;
         end
         ST_FETCH: begin
            if (mem_ready) nxt_st = ST_EXEC;
         end
         ST_EXEC: begin
            if (halt) begin
               nxt_st = ST_HALT;
            end else if (md | mw) begin
               nxt_st = ST_MEM_WAIT;
            end else begin
               upd_en = 1'b1;
               nxt_st = ST_FETCH;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ready) begin
               upd_en = 1'b1;
               nxt_st = ST_FETCH;
            end
         end
         ST_HALT: nxt_st = ST_HALT;
         default: nxt_st = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_st   <= ST_IDLE;
         pc_q     <= RESET_PC;
         ret_q    <= '0;
         state_q  <= 1'b0;
         halted_q <= 1'b0;
         lat_ps   <= PS_HOLD;
         lat_mp   <= 1'b0;
         lat_mw   <= 1'b0;
         lat_off  <= '0;
      end else begin
         cur_st   <= nxt_st;
         state_q  <= (nxt_st == ST_EXEC) || (nxt_st == ST_MEM_WAIT);
         halted_q <= (nxt_st == ST_HALT);
         if (upd_en) begin
            pc_q  <= next_pc;
            ret_q <= next_ret;
         end
         if (cur_st == ST_EXEC) begin
            lat_ps  <= ps;
            lat_mp  <= mp;
            lat_mw  <= mw;
            lat_off <= offset;
         end
      end
   end

   assign state   = state_q;
   assign halted  = halted_q;
   assign pc      = pc_q;
   assign ret_pc  = ret_q;
   assign mem_req = (cur_st == ST_FETCH) || (cur_st == ST_MEM_WAIT);
   assign mem_we  = (cur_st == ST_MEM_WAIT) && lat_mw;
   assign ir_load = (cur_st == ST_FETCH) && mem_ready;

endmodule

// File: tb/tb_pc_sequencer.sv
// Instruction-level bench for pc_sequencer: each instruction is driven
// through its fetch/execute/memory phases and compared to an arithmetic PC model.
module tb_pc_sequencer;

   logic       clk;
   logic       rst_n;
   logic       run;
   logic [1:0] ps;
   logic       mp;
   logic       md;
   logic       mw;
   logic       halt;
   logic [7:0] offset;
   logic       mem_ready;
   logic       state;
   logic [7:0] pc;
   logic [7:0] ret_pc;
   logic       mem_req;
   logic       mem_we;
   logic       ir_load;
   logic       halted;

   int n_chk = 0;
   int n_err = 0;
   int exp_pc = 0;
   int exp_ret = 0;

   pc_sequencer #(
      .PC_W     (8),
      .OFF_W    (8),
      .RESET_PC (8'h00)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .ps        (ps),
      .mp        (mp),
      .md        (md),
      .mw        (mw),
      .halt      (halt),
      .offset    (offset),
      .mem_ready (mem_ready),
      .state     (state),
      .pc        (pc),
      .ret_pc    (ret_pc),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .ir_load   (ir_load),
      .halted    (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not complete (got timeout, want finish)");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_ctrl();
      ps     = 2'($urandom_range(0, 3));
      mp     = 1'($urandom_range(0, 1));
      md     = 1'($urandom_range(0, 1));
      mw     = 1'($urandom_range(0, 1));
      offset = 8'($urandom_range(0, 255));
   endtask

   // Reference model: one architectural PC update from the instruction's rules.
   task automatic model_update(input logic [1:0] i_ps, input logic i_mp, input logic [7:0] i_off);
      int old_pc;
      int old_ret;
      old_pc  = exp_pc;
      old_ret = exp_ret;
      case (i_ps)
         2'b00: exp_pc = old_pc;
         2'b01: exp_pc = (old_pc + 1) & 255;
         2'b10: exp_pc = (old_pc + int'($signed(i_off))) & 255;
         default: exp_pc = old_ret;
      endcase
      if (i_mp) exp_ret = (old_pc + 1) & 255;
   endtask

   // Entered just after the edge that puts the DUT in FETCH; returns just
   // after the edge that starts the next FETCH (or HALT).
   task automatic do_instr(input logic [1:0] i_ps, input logic i_mp, input logic i_md,
                           input logic i_mw, input logic i_halt, input logic [7:0] i_off,
                           input int fw, input int ww);
      for (int w = 0; w < fw; w++) begin
         mem_ready = 1'b0;
         scramble_ctrl();
         #1;
         check_val("fetch_wait_req", 32'(mem_req), 32'd1);
         check_val("fetch_wait_irl", 32'(ir_load), 32'd0);
         check_val("fetch_wait_state", 32'(state), 32'd0);
         check_val("fetch_wait_pc", 32'(pc), 32'(exp_pc));
         tick();
      end
      mem_ready = 1'b1;
      #1;
      check_val("fetch_irl", 32'(ir_load), 32'd1);
      check_val("fetch_we", 32'(mem_we), 32'd0);
      check_val("fetch_state", 32'(state), 32'd0);
      tick();
      ps = i_ps; mp = i_mp; md = i_md; mw = i_mw; offset = i_off; halt = i_halt;
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check_val("exec_state", 32'(state), 32'd1);
      check_val("exec_req", 32'(mem_req), 32'd0);
      check_val("exec_irl", 32'(ir_load), 32'd0);
      check_val("exec_pc", 32'(pc), 32'(exp_pc));
      tick();
      halt = 1'b0;
      if (i_halt) begin
         #1;
         check_val("halt_flag", 32'(halted), 32'd1);
         check_val("halt_state", 32'(state), 32'd0);
         check_val("halt_req", 32'(mem_req), 32'd0);
         check_val("halt_pc", 32'(pc), 32'(exp_pc));
         check_val("halt_ret", 32'(ret_pc), 32'(exp_ret));
         return;
      end
      if (i_md | i_mw) begin
         for (int w = 0; w < ww; w++) begin
            mem_ready = 1'b0;
            scramble_ctrl();
            #1;
            check_val("mw_req", 32'(mem_req), 32'd1);
            check_val("mw_we", 32'(mem_we), 32'(i_mw));
            check_val("mw_state", 32'(state), 32'd1);
            check_val("mw_pc", 32'(pc), 32'(exp_pc));
            tick();
         end
         mem_ready = 1'b1;
         scramble_ctrl();
         #1;
         check_val("mw_done_req", 32'(mem_req), 32'd1);
         check_val("mw_done_we", 32'(mem_we), 32'(i_mw));
         check_val("mw_done_irl", 32'(ir_load), 32'd0);
         tick();
      end
      model_update(i_ps, i_mp, i_off);
      mem_ready = 1'b0;
      #1;
      check_val("next_pc", 32'(pc), 32'(exp_pc));
      check_val("next_ret", 32'(ret_pc), 32'(exp_ret));
      check_val("next_state", 32'(state), 32'd0);
      check_val("next_req", 32'(mem_req), 32'd1);
   endtask

   task automatic start_run();
      run = 1'b1;
      tick();
      run = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; ps = 2'b00; mp = 1'b0; md = 1'b0; mw = 1'b0;
      halt = 1'b0; offset = 8'h00; mem_ready = 1'b0;
      #3;
      check_val("rst_pc", 32'(pc), 32'd0);
      check_val("rst_ret", 32'(ret_pc), 32'd0);
      check_val("rst_outs", {26'd0, state, mem_req, mem_we, ir_load, halted, 1'b0}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         tick();
         check_val("idle_req", 32'(mem_req), 32'd0);
         check_val("idle_irl", 32'(ir_load), 32'd0);
         check_val("idle_state", 32'(state), 32'd0);
      end
      mem_ready = 1'b0;
      start_run();

      // sequential increments, one with a slow fetch
      do_instr(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
      do_instr(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
      do_instr(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
      do_instr(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3, 0);
      do_instr(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0);
      check_val("pc_before_store", 32'(pc), 32'h05);
      do_instr(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 2);
      check_val("pc_after_store", 32'(pc), 32'h06);

      // wrap in both directions, then link/return and swap
      do_instr(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF8, 0, 0);
      check_val("pc_fe", 32'(pc), 32'hFE);
      do_instr(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 0, 0);
      check_val("pc_wrap_up", 32'(pc), 32'h03);
      do_instr(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1, 0);
      do_instr(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFC, 0, 0);
      check_val("pc_wrap_down", 32'(pc), 32'hFE);
      do_instr(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 0, 0);
      do_instr(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 0, 0);
      check_val("link_pc", 32'(pc), 32'h30);
      check_val("link_ret", 32'(ret_pc), 32'h11);
      do_instr(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
      do_instr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
      check_val("return_pc", 32'(pc), 32'h11);
      do_instr(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 0, 0);
      do_instr(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1);
      check_val("swap_pc", 32'(pc), 32'h11);
      check_val("swap_ret", 32'(ret_pc), 32'h52);

      for (int i = 0; i < 60; i++) begin
         int kind;
         kind = int'($urandom_range(0, 2));
         do_instr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  kind == 1, kind == 2, 1'b0, 8'($urandom_range(0, 255)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      // halt has priority over a pending load
      do_instr(2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 0, 0);
      for (int i = 0; i < 4; i++) begin
         run = 1'($urandom_range(0, 1));
         mem_ready = 1'($urandom_range(0, 1));
         tick();
         check_val("halted_hold", 32'(halted), 32'd1);
         check_val("halted_req", 32'(mem_req), 32'd0);
         check_val("halted_irl", 32'(ir_load), 32'd0);
         check_val("halted_pc", 32'(pc), 32'(exp_pc));
      end
      run = 1'b0;

      // reset, new run, reset again in the middle of a store handshake
      rst_n = 1'b0;
      #1;
      check_val("rst2_halted", 32'(halted), 32'd0);
      tick();
      rst_n = 1'b1;
      exp_pc = 0;
      exp_ret = 0;
      start_run();
      do_instr(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 0, 0);
      mem_ready = 1'b1;
      tick();
      ps = 2'b01; mp = 1'b0; md = 1'b0; mw = 1'b1; mem_ready = 1'b0;
      tick();
      check_val("mid_wait_req", 32'(mem_req), 32'd1);
      check_val("mid_wait_we", 32'(mem_we), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_req", 32'(mem_req), 32'd0);
      check_val("async_rst_we", 32'(mem_we), 32'd0);
      check_val("async_rst_pc", 32'(pc), 32'd0);
      check_val("async_rst_ret", 32'(ret_pc), 32'd0);
      check_val("async_rst_state", 32'(state), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
